// File: rtl/fetch_unit_pkg.sv
// Shared types and defaults for the instruction fetch stage.
// Queue entries carry the fetch PC alongside the decode-order instruction word.
package fetch_unit_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC        = 32'h0000_0000;
  localparam int          DEFAULT_FIFO_DEPTH      = 4;
  localparam int          DEFAULT_MAX_OUTSTANDING = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } fq_entry_t;

  // Memory returns bytes in the opposite order to what decode expects.
  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: imem request/response, decode handoff and execute redirect.
// master = fetch unit side, slave = environment (imem, decode, execute).
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_ir;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output imem_req_valid, imem_req_addr, fetch_valid, fetch_pc, fetch_ir,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, fetch_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, fetch_valid, fetch_pc, fetch_ir,
    output imem_req_ready, imem_resp_valid, imem_resp_data, fetch_ready,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_unit_sync_fifo.sv
// Synchronous FIFO with flush; head visible combinationally, push-to-head latency 1 cycle.
// Push while full is accepted only when a pop happens in the same cycle; flush wins over push/pop.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_dat_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rd_dat_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o   = (count_q == CW'(DEPTH));
  assign empty_o  = (count_q == '0);
  assign count_o  = count_q;
  assign rd_dat_o = mem_q[rd_ptr_q];
  assign do_pop   = pop_i && !empty_o;
  assign do_push  = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited imem requests, prefetch queue, byte swap; resp->fetch_valid 1 cycle.
// Requests stall when the queue plus live in-flight reads would exceed the queue; responses never stall.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH      = DEFAULT_FIFO_DEPTH,
  parameter int          MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int QW = $clog2(FIFO_DEPTH + 1);

  logic [31:0] next_addr_q, next_addr_d;
  logic [OW-1:0] outst_q, outst_d, drop_q, drop_d;
  logic [QW-1:0] q_count;
  logic [OW-1:0] pc_count;
  logic          q_full, q_empty, pc_full, pc_empty;
  logic [31:0]   pc_head;
  fq_entry_t     q_wr, q_rd;
  logic          req_fire, q_push, q_pop, fetch_vld;
  logic          unused_rpc_lo;

  // Dropped responses still occupy outstanding slots but will never consume a queue slot.
  assign bus.imem_req_valid = !reset && !bus.redirect_valid
                           && (int'(outst_q) < MAX_OUTSTANDING)
                           && ((int'(q_count) + int'(outst_q) - int'(drop_q)) < FIFO_DEPTH);
  assign bus.imem_req_addr  = next_addr_q;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  assign fetch_vld       = !reset && !q_empty;
  assign q_pop           = fetch_vld && bus.fetch_ready;
  assign q_push          = bus.imem_resp_valid && (drop_q == '0) && !bus.redirect_valid;
  assign q_wr            = '{pc: pc_head, ir: bswap32(bus.imem_resp_data)};
  assign bus.fetch_valid = fetch_vld;
  assign bus.fetch_pc    = fetch_vld ? q_rd.pc : '0;
  assign bus.fetch_ir    = fetch_vld ? q_rd.ir : '0;
  assign unused_rpc_lo   = ^bus.redirect_pc[1:0];

  always_comb begin
    next_addr_d = next_addr_q;
    drop_d      = drop_q;
    outst_d     = outst_q + OW'(req_fire) - OW'(bus.imem_resp_valid);
    if (req_fire) next_addr_d = next_addr_q + 32'd4;
    if (bus.redirect_valid) begin
      next_addr_d = {bus.redirect_pc[31:2], 2'b00};
      drop_d      = outst_d;
    end else if (bus.imem_resp_valid && (drop_q != '0)) begin
      drop_d = drop_q - OW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      next_addr_q <= RESET_PC;
      outst_q     <= '0;
      drop_q      <= '0;
    end else begin
      next_addr_q <= next_addr_d;
      outst_q     <= outst_d;
      drop_q      <= drop_d;
    end
  end

  sync_fifo #(.WIDTH($bits(fq_entry_t)), .DEPTH(FIFO_DEPTH)) u_prefetch_q (
    .clk_i(clk), .rst_i(reset), .flush_i(bus.redirect_valid),
    .push_i(q_push), .push_dat_i(q_wr), .pop_i(q_pop),
    .rd_dat_o(q_rd), .count_o(q_count), .full_o(q_full), .empty_o(q_empty)
  );

  // In-flight PCs are never flushed: dropped responses still need their entry popped.
  sync_fifo #(.WIDTH(32), .DEPTH(MAX_OUTSTANDING)) u_inflight_pc (
    .clk_i(clk), .rst_i(reset), .flush_i(1'b0),
    .push_i(req_fire), .push_dat_i(next_addr_q), .pop_i(bus.imem_resp_valid),
    .rd_dat_o(pc_head), .count_o(pc_count), .full_o(pc_full), .empty_o(pc_empty)
  );

  a_resp_has_req:   assert property (@(posedge clk) disable iff (reset)
                      bus.imem_resp_valid |-> (outst_q != '0) && !pc_empty);
  a_no_q_overflow:  assert property (@(posedge clk) disable iff (reset) q_push |-> !q_full);
  a_no_pc_overflow: assert property (@(posedge clk) disable iff (reset) req_fire |-> !pc_full);
  a_pc_tracks:      assert property (@(posedge clk) disable iff (reset) pc_count == outst_q);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order imem responder and a queue-level reference model.
// The model tracks in-flight reads as live/stale and the prefetch queue as a list of {pc, ir}.
module tb_fetch_unit;
  localparam int          DEPTH  = 4;
  localparam int          MAXO   = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic        tb_reset = 1'b1, tb_rready = 1'b1, tb_fready = 1'b1, tb_redir = 1'b0;
  logic [31:0] tb_rpc = '0;
  int          lat = 1;
  int          mode = 0;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] pc; bit live; } infl_t;
  typedef struct { logic [31:0] pc; logic [31:0] ir; } ent_t;
  mreq_t memq[$];
  infl_t m_infl[$];
  ent_t  m_q[$];
  logic [31:0] m_next = RST_PC;
  bit prev_reset = 1'b0;

  logic        s_fire, s_rvalid, s_fvalid;
  logic [31:0] s_raddr, s_fpc, s_fir;

  function automatic logic [31:0] word_at(input logic [31:0] a, input int md);
    return (md == 0) ? 32'h1300_0000 : ((a * 32'h0001_0003) ^ 32'h5A13_C300);
  endfunction

  function automatic logic [31:0] ir_of(input logic [31:0] raw);
    logic [31:0] r;
    r = {<<8{raw}};
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive at negedge, compare #1 later, then advance memory and model.
  task automatic step();
    bit          exp_rv, exp_fv, resp_now;
    int          live;
    logic [31:0] rdata;
    infl_t       f;
    @(negedge clk);
    reset              = tb_reset;
    bus.imem_req_ready = tb_rready;
    bus.fetch_ready    = tb_fready;
    bus.redirect_valid = tb_redir;
    bus.redirect_pc    = tb_rpc;
    resp_now = 1'b0;
    rdata    = $urandom;
    if (tb_reset) memq.delete();
    else if (memq.size() > 0 && memq[0].due <= cyc) begin
      resp_now = 1'b1;
      rdata    = word_at(memq[0].addr, mode);
      void'(memq.pop_front());
    end
    bus.imem_resp_valid = resp_now;
    bus.imem_resp_data  = rdata;
    #1;
    live = 0;
    foreach (m_infl[i]) if (m_infl[i].live) live++;
    exp_rv = !tb_reset && !tb_redir && (m_infl.size() < MAXO) && ((m_q.size() + live) < DEPTH);
    exp_fv = !tb_reset && (m_q.size() > 0);
    s_rvalid = bus.imem_req_valid;
    s_fire   = bus.imem_req_valid && tb_rready;
    s_raddr  = bus.imem_req_addr;
    s_fvalid = bus.fetch_valid;
    s_fpc    = bus.fetch_pc;
    s_fir    = bus.fetch_ir;
    chk("req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
    if (exp_rv) chk("req_addr", bus.imem_req_addr, m_next);
    chk("fetch_valid", 32'(bus.fetch_valid), 32'(exp_fv));
    if (exp_fv) begin
      chk("fetch_pc", bus.fetch_pc, m_q[0].pc);
      chk("fetch_ir", bus.fetch_ir, m_q[0].ir);
    end
    if (tb_reset || prev_reset) begin
      chk("reset_pc_zero", bus.fetch_pc, 32'h0);
      chk("reset_ir_zero", bus.fetch_ir, 32'h0);
    end
    if (!tb_reset && bus.imem_req_valid && tb_rready)
      memq.push_back('{addr: bus.imem_req_addr, due: cyc + lat});
    if (tb_reset) begin
      m_q.delete();
      m_infl.delete();
      m_next = RST_PC;
    end else begin
      if (exp_fv && tb_fready) void'(m_q.pop_front());
      if (resp_now) begin
        if (m_infl.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL resp_unexpected: got response with no modelled request (cycle %0d)", cyc);
        end else begin
          f = m_infl.pop_front();
          if (f.live && !tb_redir) m_q.push_back('{pc: f.pc, ir: ir_of(word_at(f.pc, mode))});
        end
      end
      if (tb_redir) begin
        m_q.delete();
        foreach (m_infl[i]) m_infl[i].live = 1'b0;
        m_next = {tb_rpc[31:2], 2'b00};
      end else if (exp_rv && tb_rready) begin
        m_infl.push_back('{pc: m_next, live: 1'b1});
        m_next += 32'd4;
      end
    end
    prev_reset = tb_reset;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    tb_reset = 1'b1;
    tb_redir = 1'b0;
    repeat (n) step();
    tb_reset = 1'b0;
  endtask

  // Redirect in a steady lat-1 stream where head handshake and a response coincide.
  task automatic redir_check(input string tag, input logic [31:0] rpc);
    mode = 1; lat = 1; tb_fready = 1'b1; tb_rready = 1'b1;
    do_reset(2);
    repeat (6) step();
    tb_redir = 1'b1; tb_rpc = rpc;
    step();
    chk({tag, "_head_at_t"}, s_fpc, 32'h10);
    tb_redir = 1'b0;
    step();
    chk({tag, "_fire_t1"}, 32'(s_fire), 32'd1);
    chk({tag, "_addr_t1"}, s_raddr, 32'h100);
    chk({tag, "_empty_t1"}, 32'(s_fvalid), 32'd0);
    step();
    chk({tag, "_empty_t2"}, 32'(s_fvalid), 32'd0);
    step();
    chk({tag, "_valid_t3"}, 32'(s_fvalid), 32'd1);
    chk({tag, "_pc_t3"}, s_fpc, 32'h100);
    step();
    chk({tag, "_pc_t4"}, s_fpc, 32'h104);
  endtask

  initial begin
    logic [31:0] fired[$];
    int n;
    reset = 1'b1;
    bus.imem_req_ready = 1'b1; bus.fetch_ready = 1'b1; bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0; bus.imem_resp_valid = 1'b0; bus.imem_resp_data = '0;

    // 1: streaming, constant data
    mode = 0; lat = 1;
    do_reset(2);
    for (int k = 0; k < 8; k++) begin
      step();
      if (k < 4) begin
        chk("t1_fire", 32'(s_fire), 32'd1);
        chk("t1_addr", s_raddr, 32'(4 * k));
      end
      if (k < 2) chk("t1_not_yet", 32'(s_fvalid), 32'd0);
      else begin
        chk("t1_valid", 32'(s_fvalid), 32'd1);
        chk("t1_pc", s_fpc, 32'(4 * (k - 2)));
        chk("t1_ir", s_fir, 32'h0000_0013);
      end
    end

    // 2: decode stalled fills exactly the queue, then drains without gaps
    mode = 1; tb_fready = 1'b0;
    do_reset(2);
    for (int k = 0; k < 10; k++) begin
      step();
      if (s_fire) fired.push_back(s_raddr);
    end
    chk("t2_req_count", 32'(fired.size()), 32'd4);
    foreach (fired[i]) chk("t2_req_addr", fired[i], 32'(4 * i));
    chk("t2_req_blocked", 32'(s_rvalid), 32'd0);
    tb_fready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t2_drain_valid", 32'(s_fvalid), 32'd1);
      chk("t2_drain_pc", s_fpc, 32'(4 * k));
    end

    // 3: latency 3, redirect while 0x8/0xC are in flight
    lat = 3;
    do_reset(2);
    repeat (7) step();
    tb_redir = 1'b1; tb_rpc = 32'h100;
    step();
    tb_redir = 1'b0;
    step();
    chk("t3_fire", 32'(s_fire), 32'd1);
    chk("t3_addr", s_raddr, 32'h100);
    n = 0;
    do begin step(); n++; end while (!s_fvalid && n < 10);
    chk("t3_wait", 32'(n), 32'd4);
    chk("t3_pc", s_fpc, 32'h100);

    // 4 and 5: misaligned target and redirect colliding with response + handshake
    redir_check("t4", 32'h103);
    redir_check("t5", 32'h100);

    // 6: reset mid-operation with queued and outstanding work
    mode = 1; lat = 2; tb_fready = 1'b0;
    do_reset(2);
    repeat (6) step();
    chk("t6_pre_valid", 32'(s_fvalid), 32'd1);
    chk("t6_pre_pc", s_fpc, 32'h0);
    tb_reset = 1'b1;
    step();
    chk("t6_rst_reqv", 32'(s_rvalid), 32'd0);
    chk("t6_rst_fv", 32'(s_fvalid), 32'd0);
    tb_reset = 1'b0;
    step();
    chk("t6_after_fv", 32'(s_fvalid), 32'd0);
    chk("t6_after_fire", 32'(s_fire), 32'd1);
    chk("t6_after_addr", s_raddr, 32'h0);

    // Mixed backpressure and redirects, including targets that wrap past 2^32
    lat = 2; tb_fready = 1'b1;
    do_reset(2);
    for (int k = 0; k < 400; k++) begin
      tb_rready = ($urandom_range(0, 3) != 0);
      tb_fready = ($urandom_range(0, 4) < 3);
      tb_redir  = ($urandom_range(0, 19) == 0);
      tb_rpc    = ($urandom_range(0, 1) != 0 ? 32'hFFFF_FFF0 : 32'h0000_0200) + 32'($urandom_range(0, 15));
      step();
    end
    tb_redir = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
